// File: rtl/sie_rx.sv
// sie_rx: full-speed receive packet decoder -- PID check, CRC5/CRC16, token fields, CRC-stripped payload.
// Optional payload length limit (MAX_PACKET_SIZE) is enabled by defining SIE_RX_MAXPKT_CHECK_EN.
module sie_rx #(
    parameter int MAX_PACKET_SIZE = 64
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        usb_reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_err_i,
    input  logic        rx_ready_i,
    output logic [3:0]  pid_o,
    output logic [6:0]  addr_o,
    output logic [3:0]  endp_o,
    output logic [10:0] frame_o,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    output logic        pkt_end_o,
    output logic        pkt_err_o
);
    typedef enum logic [2:0] {ST_IDLE, ST_TOKEN, ST_DATA, ST_HSHAKE, ST_DISCARD} state_t;

    state_t      state_q;
    logic [3:0]  pid_q;
    logic [6:0]  addr_q;
    logic [3:0]  endp_q;
    logic [10:0] frame_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        pkt_end_q;
    logic        pkt_err_q;
    logic [4:0]  crc5_q, crc5_d;
    logic [15:0] crc16_q, crc16_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [10:0] tok_q;
    logic [7:0]  dly0_q, dly1_q;
    logic        eop_ok, pid_ok, too_long, pkt_done;

    function automatic logic [4:0] crc5_upd(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[4] ^ data[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[15] ^ data[i]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        crc5_d   = crc5_upd(crc5_q, rx_data_i);
        crc16_d  = crc16_upd(crc16_q, rx_data_i);
        cnt_d    = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
        pid_ok   = (rx_data_i[7:4] == ~rx_data_i[3:0]);
        pkt_done = rx_ready_i && (rx_err_i || !rx_valid_i);
        case (state_q)
            ST_TOKEN:  eop_ok = (cnt_q == 7'd2) && (crc5_q == 5'h0C);
            ST_DATA:   eop_ok = (cnt_q >= 7'd2) && (crc16_q == 16'h800D);
            ST_HSHAKE: eop_ok = 1'b1;
            default:   eop_ok = 1'b0;
        endcase
    end

`ifdef SIE_RX_MAXPKT_CHECK_EN
    // cnt_q counts payload plus the two trailing CRC bytes
    assign too_long = (int'(cnt_q) >= MAX_PACKET_SIZE + 2);
`else
    assign too_long = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            pid_q       <= 4'd0;
            addr_q      <= 7'd0;
            endp_q      <= 4'd0;
            frame_q     <= 11'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            pkt_end_q   <= 1'b0;
            pkt_err_q   <= 1'b0;
            crc5_q      <= 5'h1F;
            crc16_q     <= 16'hFFFF;
            cnt_q       <= 7'd0;
            tok_q       <= 11'd0;
            dly0_q      <= 8'd0;
            dly1_q      <= 8'd0;
        end else begin
            out_valid_q <= 1'b0;
            pkt_end_q   <= 1'b0;
            pkt_err_q   <= 1'b0;
            if (usb_reset_i || pkt_done) begin
                state_q <= ST_IDLE;
                crc5_q  <= 5'h1F;
                crc16_q <= 16'hFFFF;
                cnt_q   <= 7'd0;
                tok_q   <= 11'd0;
                dly0_q  <= 8'd0;
                dly1_q  <= 8'd0;
                if (!usb_reset_i) begin
                    pkt_end_q <= 1'b1;
                    pkt_err_q <= rx_err_i || !eop_ok;
                    if (!rx_err_i && eop_ok && state_q == ST_TOKEN) begin
                        if (pid_q == 4'b0101) begin
                            frame_q <= tok_q;
                        end else begin
                            addr_q <= tok_q[6:0];
                            endp_q <= tok_q[10:7];
                        end
                    end
                end
            end else if (rx_ready_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!pid_ok) begin
                            state_q <= ST_DISCARD;
                        end else begin
                            pid_q <= rx_data_i[3:0];
                            if (rx_data_i[1:0] == 2'b01 || rx_data_i[3:0] == 4'b0100)
                                state_q <= ST_TOKEN;
                            else if (rx_data_i[1:0] == 2'b11)
                                state_q <= ST_DATA;
                            else if (rx_data_i[1:0] == 2'b10)
                                state_q <= ST_HSHAKE;
                            else
                                state_q <= ST_DISCARD;
                        end
                    end
                    ST_TOKEN: begin
                        if (cnt_q == 7'd2) begin
                            state_q <= ST_DISCARD;
                        end else begin
                            crc5_q <= crc5_d;
                            cnt_q  <= cnt_d;
                            if (cnt_q == 7'd0) tok_q[7:0]  <= rx_data_i;
                            else               tok_q[10:8] <= rx_data_i[2:0];
                        end
                    end
                    ST_DATA: begin
                        if (too_long) begin
                            state_q <= ST_DISCARD;
                        end else begin
                            crc16_q <= crc16_d;
                            cnt_q   <= cnt_d;
                            // Two newest bytes are held back: they may turn out to be the CRC
                            if (cnt_q >= 7'd2) begin
                                out_data_q  <= dly0_q;
                                out_valid_q <= 1'b1;
                            end
                            dly0_q <= dly1_q;
                            dly1_q <= rx_data_i;
                        end
                    end
                    ST_HSHAKE: state_q <= ST_DISCARD;
                    default: ;
                endcase
            end
        end
    end

    assign pid_o       = pid_q;
    assign addr_o      = addr_q;
    assign endp_o      = endp_q;
    assign frame_o     = frame_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign pkt_end_o   = pkt_end_q;
    assign pkt_err_o   = pkt_err_q;
endmodule

// File: tb/tb_sie_rx.sv
// tb_sie_rx: randomized self-checking bench for sie_rx against a packet-level reference model.
`timescale 1ns/1ps
module tb_sie_rx;
    localparam int MAXP = 8;
    typedef logic [7:0] bq_t[$];

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        usb_reset_i = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        rx_err_i = 1'b0;
    logic        rx_ready_i = 1'b0;
    logic [3:0]  pid_o;
    logic [6:0]  addr_o;
    logic [3:0]  endp_o;
    logic [10:0] frame_o;
    logic [7:0]  out_data_o;
    logic        out_valid_o;
    logic        pkt_end_o;
    logic        pkt_err_o;

    sie_rx #(.MAX_PACKET_SIZE(MAXP)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .usb_reset_i(usb_reset_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_err_i(rx_err_i), .rx_ready_i(rx_ready_i),
        .pid_o(pid_o), .addr_o(addr_o), .endp_o(endp_o), .frame_o(frame_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .pkt_end_o(pkt_end_o), .pkt_err_o(pkt_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // Observed traffic, sampled on the falling edge
    bq_t got_q, end_q;
    int  got_cyc[$];
    int  byte_cyc[$];
    int  end_cyc = -1;
    int  eop_cyc = 0;
    always @(negedge clk_i) begin
        if (out_valid_o) begin
            got_q.push_back(out_data_o);
            got_cyc.push_back(cyc);
        end
        if (pkt_end_o) begin
            end_q.push_back({7'd0, pkt_err_o});
            end_cyc = cyc;
        end
    end

    // Reference model state
    logic [3:0]  m_pid = 4'd0;
    logic [6:0]  m_addr = 7'd0;
    logic [3:0]  m_endp = 4'd0;
    logic [10:0] m_frame = 11'd0;
    bq_t exp_pay, exp_errs;

    // Transmitted CRC5 field (wire order) for an 11-bit token value
    function automatic logic [4:0] crc5_field(input logic [10:0] v);
        logic [4:0] c;
        logic [4:0] f;
        c = 5'h1F;
        for (int i = 0; i < 11; i++)
            c = (v[i] ^ c[4]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
        for (int k = 0; k < 5; k++) f[k] = ~c[4-k];
        return f;
    endfunction

    // Transmitted CRC16 field: bits [7:0] are the first CRC byte on the wire
    function automatic logic [15:0] crc16_field(input bq_t d);
        logic [15:0] c;
        logic [15:0] f;
        c = 16'hFFFF;
        foreach (d[i])
            for (int j = 0; j < 8; j++)
                c = (d[i][j] ^ c[15]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        for (int k = 0; k < 16; k++) f[k] = ~c[15-k];
        return f;
    endfunction

    function automatic int q_diff(input bq_t a, input bq_t b);
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic bq_t gen_token(input logic [3:0] pid, input logic corrupt);
        bq_t p;
        logic [10:0] v;
        logic [4:0] f;
        v = 11'($urandom);
        f = crc5_field(v);
        if (corrupt) f = f ^ 5'(1 << $urandom_range(0, 4));
        p.push_back({~pid, pid});
        p.push_back(v[7:0]);
        p.push_back({f, v[10:8]});
        return p;
    endfunction

    function automatic bq_t gen_data(input logic [3:0] pid, input int len, input logic corrupt);
        bq_t p, pay;
        logic [15:0] f;
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
        f = crc16_field(pay);
        if (corrupt) f = f ^ 16'(1 << $urandom_range(0, 15));
        p.push_back({~pid, pid});
        foreach (pay[i]) p.push_back(pay[i]);
        p.push_back(f[7:0]);
        p.push_back(f[15:8]);
        return p;
    endfunction

    // Packet-level model: one status per packet, payload = data bytes minus the CRC pair
    task automatic model_packet(input bq_t p);
        int n, plen, emit;
        logic [3:0] pid;
        logic [10:0] v;
        logic ok;
        bq_t pay;
        ok = 1'b0;
        if (p.size() == 0) begin exp_errs.push_back(8'd1); return; end
        pid = p[0][3:0];
        if (p[0][7:4] != ~pid) begin exp_errs.push_back(8'd1); return; end
        m_pid = pid;
        n = p.size() - 1;
        if (pid[1:0] == 2'b01 || pid == 4'b0100) begin
            if (n == 2) begin
                v = {p[2][2:0], p[1]};
                ok = (p[2][7:3] == crc5_field(v));
                if (ok && pid == 4'b0101) m_frame = v;
                else if (ok) begin m_addr = v[6:0]; m_endp = v[10:7]; end
            end
        end else if (pid[1:0] == 2'b11) begin
            plen = n - 2;
            if (n >= 2) begin
                for (int i = 1; i <= plen; i++) pay.push_back(p[i]);
                ok = ({p[n], p[n-1]} == crc16_field(pay));
            end
            emit = (plen < 0) ? 0 : plen;
`ifdef SIE_RX_MAXPKT_CHECK_EN
            if (plen > MAXP) begin emit = MAXP; ok = 1'b0; end
`endif
            for (int i = 0; i < emit; i++) exp_pay.push_back(p[1+i]);
        end else if (pid[1:0] == 2'b10) begin
            ok = (n == 0);
        end
        exp_errs.push_back({7'd0, !ok});
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i = b; rx_valid_i = 1'b1; rx_err_i = 1'b0; rx_ready_i = 1'b1;
        byte_cyc.push_back(cyc);
        @(negedge clk_i);
        rx_ready_i = 1'b0; rx_valid_i = 1'b0;
    endtask

    task automatic send_eop();
        rx_valid_i = 1'b0; rx_err_i = 1'b0; rx_ready_i = 1'b1;
        eop_cyc = cyc;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
    endtask

    task automatic send_abort();
        rx_valid_i = 1'b0; rx_err_i = 1'b1; rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0; rx_err_i = 1'b0;
    endtask

    task automatic drive(input bq_t p);
        foreach (p[i]) send_byte(p[i]);
        send_eop();
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_i);
    endtask

    task automatic clear_all();
        got_q.delete(); got_cyc.delete(); end_q.delete(); byte_cyc.delete();
        exp_pay.delete(); exp_errs.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        settle();
        n_checks++;
        if ({pid_o, addr_o, endp_o, frame_o, out_data_o, out_valid_o, pkt_end_o, pkt_err_o} !== 38'd0 || end_q.size() != 0)
            begin n_fail++; $display("FAIL reset_values: got pid=%h addr=%h endp=%h frame=%h data=%h v=%b e=%b err=%b, want all 0",
                pid_o, addr_o, endp_o, frame_o, out_data_o, out_valid_o, pkt_end_o, pkt_err_o); end
    endtask

    task automatic test_token();
        bq_t p;
        logic [3:0] tok_pids[5] = '{4'h1, 4'h9, 4'hD, 4'h5, 4'h4};
        clear_all();
        p = '{8'h2D, 8'h00, 8'h10};
        drive(p);
        settle();
        n_checks++;
        if (end_q.size() != 1 || end_q[0] !== 8'd0 || end_cyc != eop_cyc + 1)
            begin n_fail++; $display("FAIL setup_token_status: got %0d ends at cyc %0d, want one ok end at cyc %0d", end_q.size(), end_cyc, eop_cyc + 1); end
        n_checks++;
        if ({pid_o, addr_o, endp_o} !== {4'hD, 7'd0, 4'd0})
            begin n_fail++; $display("FAIL setup_token_fields: got pid=%h addr=%h endp=%h, want D 0 0", pid_o, addr_o, endp_o); end
        m_pid = 4'hD; m_addr = 7'd0; m_endp = 4'd0;
        for (int i = 0; i < 14; i++) begin
            clear_all();
            p = gen_token(tok_pids[$urandom_range(0, 4)], $urandom_range(0, 3) == 0);
            model_packet(p);
            drive(p);
            settle();
            n_checks++;
            if (q_diff(end_q, exp_errs) >= 0)
                begin n_fail++; $display("FAIL token_status[%0d] pid=%h: got %0d ends err=%0d, want err=%0d", i, p[0][3:0], end_q.size(), (end_q.size() > 0) ? end_q[0] : 8'hFF, exp_errs[0]); end
            n_checks++;
            if ({pid_o, addr_o, endp_o, frame_o} !== {m_pid, m_addr, m_endp, m_frame})
                begin n_fail++; $display("FAIL token_fields[%0d]: got %h %h %h %h, want %h %h %h %h", i, pid_o, addr_o, endp_o, frame_o, m_pid, m_addr, m_endp, m_frame); end
        end
    endtask

    task automatic test_data();
        bq_t p, pay;
        logic [3:0] dat_pids[4] = '{4'h3, 4'hB, 4'h7, 4'hF};
        for (int c = 0; c < 2; c++) begin
            clear_all();
            p = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
            if (c == 1) p[10] = 8'h95;
            pay = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
            drive(p);
            settle();
            n_checks++;
            if (end_q.size() != 1 || end_q[0] !== 8'(c) || end_cyc != eop_cyc + 1)
                begin n_fail++; $display("FAIL setup_data_status[%0d]: got %0d ends err=%0d, want err=%0d", c, end_q.size(), (end_q.size() > 0) ? end_q[0] : 8'hFF, c); end
            n_checks++;
            if (q_diff(got_q, pay) >= 0 || got_cyc[0] != byte_cyc[3] + 1)
                begin n_fail++; $display("FAIL setup_data_payload[%0d]: got %0d bytes (first at cyc %0d), want 8 (first at cyc %0d)", c, got_q.size(), got_cyc[0], byte_cyc[3] + 1); end
        end
        m_pid = 4'h3;
        clear_all();
        drive('{8'hC3, 8'h00});
        settle();
        n_checks++;
        if (end_q.size() != 1 || end_q[0] !== 8'd1 || got_q.size() != 0)
            begin n_fail++; $display("FAIL short_data: got %0d ends, %0d bytes, want one error end and no bytes", end_q.size(), got_q.size()); end
        clear_all();
        drive('{8'h4B, 8'h00, 8'h00});
        settle();
        n_checks++;
        if (end_q.size() != 1 || end_q[0] !== 8'd0 || got_q.size() != 0 || pid_o !== 4'hB)
            begin n_fail++; $display("FAIL zero_len_data1: got %0d ends, %0d bytes, pid=%h, want one ok end, no bytes, pid B", end_q.size(), got_q.size(), pid_o); end
        m_pid = 4'hB;
        for (int i = 0; i < 12; i++) begin
            clear_all();
            p = gen_data(dat_pids[$urandom_range(0, 3)], $urandom_range(0, 12), $urandom_range(0, 3) == 0);
            model_packet(p);
            drive(p);
            settle();
            n_checks++;
            if (q_diff(end_q, exp_errs) >= 0)
                begin n_fail++; $display("FAIL data_status[%0d] len=%0d: got %0d ends err=%0d, want err=%0d", i, p.size(), end_q.size(), (end_q.size() > 0) ? end_q[0] : 8'hFF, exp_errs[0]); end
            n_checks++;
            if (q_diff(got_q, exp_pay) >= 0 || pid_o !== m_pid)
                begin n_fail++; $display("FAIL data_payload[%0d]: got %0d bytes pid=%h, want %0d bytes pid=%h, first diff at %0d", i, got_q.size(), pid_o, exp_pay.size(), m_pid, q_diff(got_q, exp_pay)); end
        end
    endtask

    task automatic test_hshake_and_bad_pid();
        bq_t p;
        // D2 ok, D2 00 err, 2C bad complement (pid kept), 3C special PID (pid taken), bare EOP, token with 3rd byte
        bq_t pkts[6];
        logic [7:0] want_err[6] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        logic [3:0] want_pid[6] = '{4'h2, 4'h2, 4'h2, 4'hC, 4'hC, 4'h9};
        pkts[0] = '{8'hD2};
        pkts[1] = '{8'hD2, 8'h00};
        pkts[2] = '{8'h2C};
        pkts[3] = '{8'h3C, 8'h11};
        pkts[4] = '{};
        pkts[5] = '{8'h69, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 6; i++) begin
            clear_all();
            drive(pkts[i]);
            settle();
            n_checks++;
            if (end_q.size() != 1 || end_q[0] !== want_err[i] || pid_o !== want_pid[i])
                begin n_fail++; $display("FAIL hshake_badpid[%0d]: got %0d ends err=%0d pid=%h, want err=%0d pid=%h", i, end_q.size(), (end_q.size() > 0) ? end_q[0] : 8'hFF, pid_o, want_err[i], want_pid[i]); end
        end
        m_pid = 4'h9;
        // Setting a known address first makes the abort check meaningful
        clear_all();
        p = '{8'h69, 8'h00, 8'h10};
        p[1] = 8'h05;
        p[2] = {crc5_field(11'h005), 3'b000};
        drive(p);
        send_byte(8'h69); send_byte(8'h00); send_abort();
        settle();
        n_checks++;
        if (end_q.size() != 2 || end_q[0] !== 8'd0 || end_q[1] !== 8'd1 || addr_o !== 7'd5)
            begin n_fail++; $display("FAIL abort: got %0d ends addr=%h, want ok then error, addr 05", end_q.size(), addr_o); end
        m_addr = 7'd5; m_endp = 4'd0;
    endtask

    task automatic test_maxpkt();
        bq_t p;
        bq_t want;
        clear_all();
        p = gen_data(4'h3, 9, 1'b0);
        for (int i = 1; i <= 9; i++) want.push_back(p[i]);
`ifdef SIE_RX_MAXPKT_CHECK_EN
        want = want[0:MAXP-1];
`endif
        drive(p);
        settle();
        n_checks++;
`ifdef SIE_RX_MAXPKT_CHECK_EN
        if (end_q.size() != 1 || end_q[0] !== 8'd1)
`else
        if (end_q.size() != 1 || end_q[0] !== 8'd0)
`endif
            begin n_fail++; $display("FAIL maxpkt_status: got %0d ends err=%0d", end_q.size(), (end_q.size() > 0) ? end_q[0] : 8'hFF); end
        n_checks++;
        if (q_diff(got_q, want) >= 0)
            begin n_fail++; $display("FAIL maxpkt_payload: got %0d strobes, want %0d", got_q.size(), want.size()); end
        m_pid = 4'h3;
    endtask

    task automatic test_back_to_back();
        bq_t p;
        clear_all();
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: p = gen_token(4'h1, $urandom_range(0, 2) == 0);
                1: p = gen_data(4'hB, $urandom_range(0, 10), $urandom_range(0, 2) == 0);
                2: p = '{8'h5A};
                default: p = '{8'(($urandom_range(0, 1) == 0) ? 8'hE1 : 8'h0F)};
            endcase
            model_packet(p);
            drive(p);
        end
        settle();
        n_checks++;
        if (q_diff(end_q, exp_errs) >= 0)
            begin n_fail++; $display("FAIL b2b_status: got %0d ends, want %0d, first diff at %0d", end_q.size(), exp_errs.size(), q_diff(end_q, exp_errs)); end
        n_checks++;
        if (q_diff(got_q, exp_pay) >= 0)
            begin n_fail++; $display("FAIL b2b_payload: got %0d bytes, want %0d, first diff at %0d", got_q.size(), exp_pay.size(), q_diff(got_q, exp_pay)); end
        n_checks++;
        if ({pid_o, addr_o, endp_o, frame_o} !== {m_pid, m_addr, m_endp, m_frame})
            begin n_fail++; $display("FAIL b2b_fields: got %h %h %h %h, want %h %h %h %h", pid_o, addr_o, endp_o, frame_o, m_pid, m_addr, m_endp, m_frame); end
    endtask

    task automatic test_usb_reset();
        clear_all();
        send_byte(8'hC3); send_byte(8'h11); send_byte(8'h22);
        usb_reset_i = 1'b1;
        @(negedge clk_i);
        usb_reset_i = 1'b0;
        settle();
        n_checks++;
        if (end_q.size() != 0 || got_q.size() != 0)
            begin n_fail++; $display("FAIL usb_reset_quiet: got %0d ends %0d bytes, want none", end_q.size(), got_q.size()); end
        drive('{8'h69, 8'h00, 8'h10});
        settle();
        n_checks++;
        if (end_q.size() != 1 || end_q[0] !== 8'd0 || {pid_o, addr_o, endp_o} !== {4'h9, 7'd0, 4'd0})
            begin n_fail++; $display("FAIL usb_reset_next: got %0d ends pid=%h addr=%h endp=%h, want one ok end, 9 0 0", end_q.size(), pid_o, addr_o, endp_o); end
    endtask

    task automatic test_rstn();
        clear_all();
        send_byte(8'hC3); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44);
        #2 rstn_i = 1'b0;
        #1;
        n_checks++;
        if ({pid_o, addr_o, endp_o, frame_o, out_data_o, out_valid_o, pkt_end_o, pkt_err_o} !== 38'd0)
            begin n_fail++; $display("FAIL rstn_async: got pid=%h data=%h v=%b e=%b, want all 0", pid_o, out_data_o, out_valid_o, pkt_end_o); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        settle();
        clear_all();
        drive('{8'h2D, 8'h00, 8'h10});
        settle();
        n_checks++;
        if (end_q.size() != 1 || end_q[0] !== 8'd0 || got_q.size() != 0 || pid_o !== 4'hD)
            begin n_fail++; $display("FAIL rstn_next: got %0d ends %0d bytes pid=%h, want one ok end, pid D", end_q.size(), got_q.size(), pid_o); end
    endtask

    initial begin
        test_reset();
        test_token();
        test_data();
        test_hshake_and_bad_pid();
        test_maxpkt();
        test_back_to_back();
        test_usb_reset();
        test_rstn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sie_rx.md
# sie_rx

Receive-side packet decoder of the SIE, directly downstream of the full-speed PHY receiver. Consumes the PHY byte/error/EOP strobe handshake, validates the PID and the CRC5/CRC16, and extracts token fields. Forwards the data payload with both CRC bytes stripped, then reports one end-of-packet status per packet to the SIE control logic.

## Interface
- MAX_PACKET_SIZE, 64: largest accepted data payload in bytes; used only with the length-check macro.
- clk_i  in  1  clock, 12MHz*BIT_SAMPLES; same clock as the PHY receiver.
- rstn_i  in  1  reset; asynchronous, active-low.
- usb_reset_i  in  1  bus reset from PHY; while high, synchronously forces ST_IDLE and drops all strobes.
- rx_data_i  in  8  received byte, LSB first on wire.
- rx_valid_i  in  1  byte qualifier.
- rx_err_i  in  1  PHY abort qualifier.
- rx_ready_i  in  1  one-cycle strobe; valid=1 is a byte, err=1 is an abort, both 0 is an EOP.
- pid_o  out  4  PID of current/last packet, updated on PID acceptance.
- addr_o  out  7  token address.
- endp_o  out  4  token endpoint.
- frame_o  out  11  SOF frame number.
- out_data_o  out  8  payload byte.
- out_valid_o  out  1  one-cycle payload byte strobe.
- pkt_end_o  out  1  one-cycle end-of-packet strobe.
- pkt_err_o  out  1  status qualifier, valid with pkt_end_o; 1 = packet bad.

## Operation
- States: ST_IDLE, ST_TOKEN, ST_DATA, ST_HSHAKE, ST_DISCARD.
- ST_IDLE, byte received: the PID check requires rx_data_i[7:4] == ~rx_data_i[3:0]. On failure go to ST_DISCARD.
- On PID check pass, register pid_o = rx_data_i[3:0] and branch on it:
  - [1:0]==01 or PID 0100 (PING): go to ST_TOKEN.
  - [1:0]==11: go to ST_DATA.
  - [1:0]==10: go to ST_HSHAKE.
  - Any other special PID: go to ST_DISCARD.
- ST_TOKEN:
  - Collects exactly 2 bytes, with CRC5 (poly 0x05, init 0x1F) run LSB-first over 16 bits. The residual must be 0x0C.
  - Address is byte1[6:0]; endpoint is {byte2[2:0],byte1[7]}; frame is {byte2[2:0],byte1}.
  - A 3rd byte goes to ST_DISCARD.
  - At EOP, when the byte count is 2 and the CRC is good, load addr_o/endp_o (or frame_o for SOF, PID 0101) and report ok. Otherwise report error. Token outputs are unchanged on error.
- ST_DATA:
  - CRC16 (poly 0x8005, init 0xFFFF) runs over every byte. At EOP the residual must be 0x800D.
  - A 2-byte delay line holds the newest bytes. Each received byte beyond the 2nd pushes the oldest byte out as out_data_o with out_valid_o. The CRC bytes are never emitted.
  - Payload length is the byte count minus 2. EOP with fewer than 2 bytes after the PID is an error.
- ST_HSHAKE: EOP reports ok; any byte goes to ST_DISCARD.
- ST_DISCARD: ignores bytes; EOP reports error.
- In any state, an rx_err_i strobe reports error and returns to ST_IDLE.
- In ST_IDLE, an EOP with no PID reports error.
- Every pkt_end_o returns the FSM to ST_IDLE and clears the CRC registers, counters and delay line.
- Payload bytes already emitted are not retracted; the consumer drops them when pkt_err_o=1.
- Byte counter is 7 bits and saturates at 127.

## Timing
- All outputs are registered.
- out_valid_o and pkt_end_o assert exactly 1 clk after the causing rx_ready_i strobe.
- addr_o, endp_o, frame_o and pid_o are stable from pkt_end_o until the next update.
- rx_ready_i strobes may arrive back-to-back (EOP 1 clk after the last byte). No input is lost and there are no stall paths.
- Reset values: pid_o=0, addr_o=0, endp_o=0, frame_o=0, out_data_o=0, out_valid_o=0, pkt_end_o=0, pkt_err_o=0, state ST_IDLE.
- usb_reset_i mid-packet: no pkt_end_o is generated, and the next PID starts clean.
- rstn_i mid-packet: immediate return to the reset values.

## Configuration
- SIE_RX_MAXPKT_CHECK_EN defined:
  - In ST_DATA, a byte that would make the payload exceed MAX_PACKET_SIZE goes to ST_DISCARD, and no further out_valid_o is generated.
  - The packet ends with pkt_err_o=1.
- Not defined: no length limit; the counter saturates and CRC alone decides status.

## Test plan
- Bytes 2D 00 10, then EOP -> pid_o=D, addr_o=0, endp_o=0, pkt_end_o with pkt_err_o=0.
- Bytes C3 80 06 00 01 00 00 40 00 DD 94, then EOP -> 8 out_valid_o strobes carrying 80 06 00 01 00 00 40 00, then pkt_end_o with pkt_err_o=0. With last byte 95 instead -> pkt_err_o=1.
- Bytes 4B 00 00, then EOP -> no out_valid_o, pkt_end_o ok. Bytes D2 then EOP -> pid_o=2, ok. Bytes D2 00 then EOP -> error.
- Byte 2C (bad complement), then EOP -> pid_o unchanged, pkt_err_o=1. rx_err_i strobe after 69 00 -> pkt_end_o error, addr_o unchanged.
- Macro on, MAX_PACKET_SIZE=8: DATA0 with 9 payload bytes plus valid CRC -> exactly 8 out_valid_o, pkt_err_o=1. Macro off -> 9 strobes, ok.
- usb_reset_i pulse after C3 11 22 -> no pkt_end_o. A following 69 00 10 decodes ok.
